// File: rtl/led_shift_ctrl.sv
// led_shift_ctrl: prescaled shift-enable pulses, shift direction (button / ping-pong) and lit LED index.
// Define SHIFT_CTRL_DEBOUNCE_EN to debounce the synchronized button before edge detection.
module led_shift_ctrl #(
  parameter int N_LEDS    = 4,
  parameter int CNT_W     = 32,
  parameter int LIM0      = 50_000_000,
  parameter int LIM1      = 25_000_000,
  parameter int LIM2      = 12_500_000,
  parameter int LIM3      = 6_250_000,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  input  logic [1:0]                i_speed_sel,
  input  logic                      i_btn_dir,
  input  logic                      i_mode,
  output logic                      o_shift_enable,
  output logic                      o_shift_dir,
  output logic [$clog2(N_LEDS)-1:0] o_pos
);
  localparam int PW = $clog2(N_LEDS);
  typedef enum logic {LOOP, PING} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, lim;
  logic [1:0] sync;
  logic lvl, lvl_q, btn_rise, dir_n;
  logic [PW-1:0] pos_n;
  always_comb lim = i_speed_sel == 2'd0 ? CNT_W'(LIM0) :
                    i_speed_sel == 2'd1 ? CNT_W'(LIM1) :
                    i_speed_sel == 2'd2 ? CNT_W'(LIM2) : CNT_W'(LIM3);
  // >= rather than == so a speed change below the current count fires at once instead of overflowing
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      o_shift_enable <= 1'b0;
    end else if (!i_enable) begin
      o_shift_enable <= 1'b0;
    end else if (cnt >= lim - CNT_W'(1)) begin
      cnt <= '0;
      o_shift_enable <= 1'b1;
    end else begin
      cnt <= cnt + CNT_W'(1);
      o_shift_enable <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync <= '0;
      lvl_q <= 1'b0;
    end else begin
      sync <= {sync[0], i_btn_dir};
      lvl_q <= lvl;
    end
`ifdef SHIFT_CTRL_DEBOUNCE_EN
  localparam int DBW = $clog2(DB_CYCLES + 1);
  logic [DBW-1:0] db_cnt;
  logic db_lvl;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync[1] == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == DBW'(DB_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= sync[1];
    end else begin
      db_cnt <= db_cnt + DBW'(1);
    end
  assign lvl = db_lvl;
`else
  assign lvl = sync[1];
`endif
  assign btn_rise = lvl & ~lvl_q;
  // pos follows the shift register, which moves on the cycle o_shift_enable is high
  always_comb begin
    state_n = i_mode ? PING : LOOP;
    pos_n = !o_shift_enable ? o_pos :
            o_shift_dir ? (o_pos == '0 ? PW'(N_LEDS - 1) : o_pos - PW'(1)) :
            (o_pos == PW'(N_LEDS - 1) ? '0 : o_pos + PW'(1));
    dir_n = state == LOOP ? o_shift_dir ^ btn_rise :
            pos_n == PW'(N_LEDS - 1) ? 1'b1 :
            pos_n == '0 ? 1'b0 : o_shift_dir;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= LOOP;
      o_pos <= '0;
      o_shift_dir <= 1'b0;
    end else begin
      state <= state_n;
      o_pos <= pos_n;
      o_shift_dir <= dir_n;
    end
endmodule

// File: tb/tb_led_shift_ctrl.sv
// tb_led_shift_ctrl: directed checks of prescaler, position, direction, ping-pong and button handling.
module tb_led_shift_ctrl;
  logic clk = 1'b0, rst = 1'b1, i_enable = 1'b0, i_btn_dir = 1'b0, i_mode = 1'b0;
  logic [1:0] i_speed_sel = 2'd0;
  logic o_shift_enable, o_shift_dir;
  logic [1:0] o_pos;
  int checks = 0, errors = 0;

  led_shift_ctrl #(.N_LEDS(4), .CNT_W(32), .LIM0(4), .LIM1(16), .LIM2(8), .LIM3(2), .DB_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable), .i_speed_sel(i_speed_sel), .i_btn_dir(i_btn_dir),
    .i_mode(i_mode), .o_shift_enable(o_shift_enable), .o_shift_dir(o_shift_dir), .o_pos(o_pos));

  always #5 clk = ~clk;

  task automatic pulse_pos(input logic [1:0] ep, input logic ed);
    int n = 0;
    do begin @(negedge clk); n++; end while (!o_shift_enable && n < 40);
    checks++;
    if (o_shift_enable !== 1'b1) begin errors++; $display("FAIL pulse_timeout got %b want 1", o_shift_enable); end
    @(negedge clk);
    checks++;
    if (o_pos !== ep) begin errors++; $display("FAIL pulse_pos got %0d want %0d", o_pos, ep); end
    checks++;
    if (o_shift_dir !== ed) begin errors++; $display("FAIL pulse_dir got %b want %b", o_shift_dir, ed); end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({o_shift_enable, o_shift_dir, o_pos} !== 4'b0) begin
      errors++; $display("FAIL reset_outputs got %b want 0000", {o_shift_enable, o_shift_dir, o_pos});
    end
    rst = 1'b0;
  endtask

  task automatic test_prescaler;
    i_enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== (k % 4 == 0)) begin
        errors++; $display("FAIL prescale_pulse cycle %0d got %b want %b", k, o_shift_enable, k % 4 == 0);
      end
    end
    checks++;
    if (o_pos !== 2'd2) begin errors++; $display("FAIL prescale_pos got %0d want 2", o_pos); end
    pulse_pos(2'd3, 1'b0);
  endtask

  task automatic test_freeze;
    i_enable = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== 1'b0) begin errors++; $display("FAIL freeze_pulse cycle %0d got 1 want 0", k); end
    end
    checks++;
    if (o_pos !== 2'd3) begin errors++; $display("FAIL freeze_pos got %0d want 3", o_pos); end
    i_enable = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== (k == 3)) begin
        errors++; $display("FAIL freeze_resume cycle %0d got %b want %b", k, o_shift_enable, k == 3);
      end
    end
    @(negedge clk);
    checks++;
    if (o_pos !== 2'd0) begin errors++; $display("FAIL freeze_wrap got %0d want 0", o_pos); end
  endtask

  task automatic test_button_loop;
    i_btn_dir = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_shift_enable, o_shift_dir} !== 2'b11) begin
      errors++; $display("FAIL btn_toggle got en/dir %b want 11", {o_shift_enable, o_shift_dir});
    end
    @(negedge clk);
    checks++;
    if (o_pos !== 2'd3) begin errors++; $display("FAIL btn_der_wrap got %0d want 3", o_pos); end
    i_btn_dir = 1'b0;
    pulse_pos(2'd2, 1'b1);
  endtask

  task automatic test_btn_on_pulse;
    @(negedge clk);
    i_btn_dir = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({o_shift_enable, o_shift_dir} !== 2'b11) begin
      errors++; $display("FAIL coinc_pre got en/dir %b want 11", {o_shift_enable, o_shift_dir});
    end
    @(negedge clk);
    checks++;
    if ({o_pos, o_shift_dir} !== 3'b010) begin
      errors++; $display("FAIL coinc_edge got pos/dir %b want 010", {o_pos, o_shift_dir});
    end
    i_btn_dir = 1'b0;
    pulse_pos(2'd2, 1'b0);
  endtask

  task automatic test_pingpong;
    pulse_pos(2'd3, 1'b0);
    pulse_pos(2'd0, 1'b0);
    i_mode = 1'b1;
    pulse_pos(2'd1, 1'b0);
    pulse_pos(2'd2, 1'b0);
    pulse_pos(2'd3, 1'b1);
    i_btn_dir = 1'b1;
    pulse_pos(2'd2, 1'b1);
    i_btn_dir = 1'b0;
    pulse_pos(2'd1, 1'b1);
    pulse_pos(2'd0, 1'b0);
    pulse_pos(2'd1, 1'b0);
    i_mode = 1'b0;
  endtask

  task automatic test_speed_change;
    i_speed_sel = 2'd1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== 1'b0) begin errors++; $display("FAIL speed1_early cycle %0d got 1 want 0", k); end
    end
    i_speed_sel = 2'd0;
    @(negedge clk);
    checks++;
    if (o_shift_enable !== 1'b1) begin errors++; $display("FAIL speed_switch got 0 want 1"); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== (k == 4)) begin
        errors++; $display("FAIL speed_period cycle %0d got %b want %b", k, o_shift_enable, k == 4);
      end
    end
    checks++;
    if (o_pos !== 2'd2) begin errors++; $display("FAIL speed_pos got %0d want 2", o_pos); end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    #1;
    checks++;
    if ({o_shift_enable, o_shift_dir, o_pos} !== 4'b0) begin
      errors++; $display("FAIL async_reset got %b want 0000", {o_shift_enable, o_shift_dir, o_pos});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (o_shift_enable !== (k == 4)) begin
        errors++; $display("FAIL reset_release cycle %0d got %b want %b", k, o_shift_enable, k == 4);
      end
    end
  endtask

  task automatic test_glitch;
    logic eg, eh;
`ifdef SHIFT_CTRL_DEBOUNCE_EN
    eg = 1'b0; eh = 1'b1;
`else
    eg = 1'b1; eh = 1'b0;
`endif
    i_enable = 1'b0;
    @(negedge clk);
    i_btn_dir = 1'b1;
    repeat (3) @(negedge clk);
    i_btn_dir = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (o_shift_dir !== eg) begin errors++; $display("FAIL glitch_dir got %b want %b", o_shift_dir, eg); end
    i_btn_dir = 1'b1;
    repeat (12) @(negedge clk);
    i_btn_dir = 1'b0;
    repeat (15) @(negedge clk);
    checks++;
    if (o_shift_dir !== eh) begin errors++; $display("FAIL hold_dir got %b want %b", o_shift_dir, eh); end
  endtask

  initial begin
    test_reset;
    test_prescaler;
    test_freeze;
    test_button_loop;
    test_btn_on_pulse;
    test_pingpong;
    test_speed_change;
    test_reset_mid;
    test_glitch;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
